// File: rtl/bp_pkg.sv
// Shared types, counter constants and the saturating-counter step for the gshare predictor.
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t CTR_SNT = 2'b00;
    localparam bp_ctr_t CTR_WNT = 2'b01;
    localparam bp_ctr_t CTR_WT  = 2'b10;
    localparam bp_ctr_t CTR_ST  = 2'b11;

    typedef enum logic {BP_CONCAT = 1'b0, BP_XOR = 1'b1} bp_mode_e;
    typedef enum logic {BP_INIT = 1'b0, BP_READY = 1'b1} bp_state_e;

    // One step of a 2-bit counter toward the resolved direction, saturating at both ends.
    function automatic bp_ctr_t ctr_next(bp_ctr_t ctr, logic taken);
        case (ctr)
            CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
            default: return taken ? CTR_ST  : CTR_WT;
        endcase
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters with an INIT sweep that clears one entry per cycle,
// an asynchronous read port and a saturating update port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_index,
    output logic             taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic             wr_outcome,
    output logic             ready
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    bp_ctr_t          pht [DEPTH];
    bp_state_e        state;
    logic [IDX_W-1:0] ptr;

    // The counter array is never reset directly; the sweep rewrites every entry after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BP_INIT;
            ptr   <= '0;
        end else begin
            case (state)
                BP_INIT: begin
                    pht[ptr] <= CTR_WNT;
                    ptr      <= ptr + IDX_W'(1);
                    if (ptr == '1) begin
                        state <= BP_READY;
                    end
                end
                BP_READY: begin
                    if (wr_en) begin
                        pht[wr_index] <= ctr_next(pht[wr_index], wr_outcome);
                    end
                end
            endcase
        end
    end

    assign ready = (state == BP_READY);
    assign taken = ready & pht[lookup_index][1];

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: index hashing, speculative/architectural history with
// mispredict recovery, and a saturating mispredict counter around the bp_pht table.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned HIST_W = 4,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned MODE   = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              lookup_valid,
    output logic              prediction,
    output logic [IDX_W-1:0]  read_index,
    output logic              ready,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_index,
    input  logic              update_outcome,
    input  logic              update_mispredict,
    output logic [HIST_W-1:0] ghr_spec,
    output logic [CNT_W-1:0]  mispredict_count
);

    if (PC_W < IDX_W || HIST_W < 1 || HIST_W > IDX_W || MODE > 1) begin : g_param_check
        $error("gshare_predictor: need PC_W >= IDX_W, 1 <= HIST_W <= IDX_W, MODE in {0,1}");
    end

    localparam bp_mode_e HASH_MODE = (MODE == 1) ? BP_XOR : BP_CONCAT;

    logic [HIST_W-1:0] ghr_arch;
    logic [HIST_W-1:0] ghr_arch_next;
    logic              recover;
    logic              unused_pc;

    function automatic logic [HIST_W-1:0] shift_in(logic [HIST_W-1:0] hist, logic bit_in);
        return HIST_W'({hist, bit_in});
    endfunction

    if (HASH_MODE == BP_XOR) begin : g_xor
        assign read_index = pc[IDX_W-1:0] ^ IDX_W'(ghr_spec);
    end else if (HIST_W == IDX_W) begin : g_cat_full
        assign read_index = ghr_spec;
    end else begin : g_cat
        assign read_index = {pc[IDX_W-HIST_W-1:0], ghr_spec};
    end

    // Upper PC bits beyond the hash are deliberately ignored.
    assign unused_pc = ^pc;

    bp_pht #(
        .IDX_W(IDX_W)
    ) u_pht (
        .clk         (clk),
        .rst         (rst),
        .lookup_index(read_index),
        .taken       (prediction),
        .wr_en       (update_valid & ready),
        .wr_index    (update_index),
        .wr_outcome  (update_outcome),
        .ready       (ready)
    );

    assign ghr_arch_next = shift_in(ghr_arch, update_outcome);
    assign recover       = update_valid & update_mispredict;

    // Recovery overrides a same-cycle lookup shift of the speculative history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_spec         <= '0;
            ghr_arch         <= '0;
            mispredict_count <= '0;
        end else if (ready) begin
            if (update_valid) begin
                ghr_arch <= ghr_arch_next;
            end
            if (recover) begin
                ghr_spec <= ghr_arch_next;
                if (mispredict_count != '1) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
            end else if (lookup_valid) begin
                ghr_spec <= shift_in(ghr_spec, prediction);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a concatenation instance and an XOR/2-bit-counter instance share
// one stimulus stream; an abstract model is compared every cycle alongside directed literal checks.
module tb_gshare_predictor;

    logic       clk;
    logic       rst;
    logic [7:0] pc;
    logic       lookup_valid;
    logic       update_valid;
    logic [7:0] update_index;
    logic       update_outcome;
    logic       update_mispredict;

    logic        pred0, rdy0;
    logic [7:0]  idx0;
    logic [3:0]  gs0;
    logic [15:0] cnt0;
    logic        pred1, rdy1;
    logic [7:0]  idx1;
    logic [3:0]  gs1;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    gshare_predictor #(
        .PC_W(8), .HIST_W(4), .IDX_W(8), .MODE(0), .CNT_W(16)
    ) u_cat (
        .clk(clk), .rst(rst), .pc(pc), .lookup_valid(lookup_valid),
        .prediction(pred0), .read_index(idx0), .ready(rdy0),
        .update_valid(update_valid), .update_index(update_index),
        .update_outcome(update_outcome), .update_mispredict(update_mispredict),
        .ghr_spec(gs0), .mispredict_count(cnt0)
    );

    gshare_predictor #(
        .PC_W(8), .HIST_W(4), .IDX_W(8), .MODE(1), .CNT_W(2)
    ) u_xor (
        .clk(clk), .rst(rst), .pc(pc), .lookup_valid(lookup_valid),
        .prediction(pred1), .read_index(idx1), .ready(rdy1),
        .update_valid(update_valid), .update_index(update_index),
        .update_outcome(update_outcome), .update_mispredict(update_mispredict),
        .ghr_spec(gs1), .mispredict_count(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model ----------------
    // Counters held as integers 0..3; history as an integer modulo 16.
    int m_tbl [256];
    int m_gs0, m_gs1, m_ga, m_c0, m_c1, m_sweep;
    bit m_ready, m_valid;
    int m_i0, m_i1, m_na;
    bit m_p0, m_p1;

    function automatic int hash_cat(int p, int g);
        return (p % 16) * 16 + g;
    endfunction

    function automatic int hash_xor(int p, int g);
        return (p % 256) ^ g;
    endfunction

    initial m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_ready = 0; m_sweep = 0;
            m_gs0 = 0; m_gs1 = 0; m_ga = 0; m_c0 = 0; m_c1 = 0;
        end else if (m_valid) begin
            if (!m_ready) begin
                m_sweep++;
                if (m_sweep == 256) begin
                    m_ready = 1;
                    foreach (m_tbl[i]) m_tbl[i] = 1;
                end
            end else begin
                m_i0 = hash_cat(pc, m_gs0);
                m_i1 = hash_xor(pc, m_gs1);
                m_p0 = m_tbl[m_i0] >= 2;
                m_p1 = m_tbl[m_i1] >= 2;
                m_na = (m_ga * 2 + update_outcome) % 16;
                if (update_valid) begin
                    if (update_outcome) m_tbl[update_index] = (m_tbl[update_index] == 3) ? 3 : m_tbl[update_index] + 1;
                    else                m_tbl[update_index] = (m_tbl[update_index] == 0) ? 0 : m_tbl[update_index] - 1;
                    m_ga = m_na;
                end
                if (update_valid && update_mispredict) begin
                    m_gs0 = m_na;
                    m_gs1 = m_na;
                    m_c0 = (m_c0 == 65535) ? 65535 : m_c0 + 1;
                    m_c1 = (m_c1 == 3) ? 3 : m_c1 + 1;
                end else if (lookup_valid) begin
                    m_gs0 = (m_gs0 * 2 + int'(m_p0)) % 16;
                    m_gs1 = (m_gs1 * 2 + int'(m_p1)) % 16;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ready_cat", 32'(rdy0), 32'(m_ready));
            chk("m_ready_xor", 32'(rdy1), 32'(m_ready));
            chk("m_index_cat", 32'(idx0), hash_cat(pc, m_gs0));
            chk("m_index_xor", 32'(idx1), hash_xor(pc, m_gs1));
            chk("m_pred_cat", 32'(pred0), 32'(m_ready && m_tbl[hash_cat(pc, m_gs0)] >= 2));
            chk("m_pred_xor", 32'(pred1), 32'(m_ready && m_tbl[hash_xor(pc, m_gs1)] >= 2));
            chk("m_ghr_cat", 32'(gs0), m_gs0);
            chk("m_ghr_xor", 32'(gs1), m_gs1);
            chk("m_cnt_cat", 32'(cnt0), m_c0);
            chk("m_cnt_xor", 32'(cnt1), m_c1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lookup_valid = 0; update_valid = 0; update_index = '0;
        update_outcome = 0; update_mispredict = 0;
    endtask

    task automatic do_update(input logic [7:0] i, input logic o, input logic m);
        update_valid = 1; update_index = i; update_outcome = o; update_mispredict = m;
        cyc();
        update_valid = 0; update_mispredict = 0; update_outcome = 0;
    endtask

    logic [7:0] pre_idx [6];
    logic [7:0] cat_idx [3];
    logic [7:0] xor_idx [3];

    initial begin
        pre_idx = '{8'h00, 8'h01, 8'h03, 8'h10, 8'h11, 8'h13};
        cat_idx = '{8'h00, 8'h01, 8'h03};
        xor_idx = '{8'h10, 8'h11, 8'h13};
        rst = 1; pc = '0;
        clear_inputs();
        cyc();
        rst = 0;

        // ready low for exactly 256 cycles after reset release
        for (int i = 0; i < 256; i++) begin
            #1 chk("init_not_ready", 32'(rdy0), 0);
            chk("init_pred_zero", 32'(pred0), 0);
            cyc();
        end
        #1 chk("ready_after_sweep_cat", 32'(rdy0), 1);
        chk("ready_after_sweep_xor", 32'(rdy1), 1);

        for (int p = 0; p < 256; p++) begin
            pc = 8'(p);
            #1 chk("all_weak_not_taken", 32'(pred1), 0);
        end
        cyc();

        for (int k = 0; k < 6; k++) do_update(pre_idx[k], 1'b1, 1'b0);

        // saturating counter walk on index 0x35
        do_update(8'h35, 1'b1, 1'b0);
        do_update(8'h35, 1'b1, 1'b0);
        pc = 8'h35;
        #1 chk("idx_35", 32'(idx1), 32'h35);
        chk("pred_35_after_2_taken", 32'(pred1), 1);
        for (int k = 0; k < 3; k++) do_update(8'h35, 1'b1, 1'b0);
        do_update(8'h35, 1'b0, 1'b0);
        #1 chk("pred_35_from_st_1nt", 32'(pred1), 1);
        do_update(8'h35, 1'b0, 1'b0);
        #1 chk("pred_35_2nt", 32'(pred1), 0);
        do_update(8'h35, 1'b0, 1'b0);
        do_update(8'h35, 1'b0, 1'b0);
        do_update(8'h35, 1'b0, 1'b0);
        #1 chk("pred_35_floor_held", 32'(pred1), 0);

        update_mispredict = 1;
        cyc();
        update_mispredict = 0;
        #1 chk("mispredict_without_valid_cnt", 32'(cnt0), 0);
        chk("mispredict_without_valid_ghr", 32'(gs0), 0);

        // three predicted-taken lookups, then recovery with a same-cycle lookup
        pc = 8'h10; lookup_valid = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("lookup_idx_cat", 32'(idx0), 32'(cat_idx[k]));
            chk("lookup_idx_xor", 32'(idx1), 32'(xor_idx[k]));
            chk("lookup_pred_cat", 32'(pred0), 1);
            chk("lookup_pred_xor", 32'(pred1), 1);
            cyc();
        end
        #1 chk("ghr_spec_0111_cat", 32'(gs0), 32'h7);
        chk("ghr_spec_0111_xor", 32'(gs1), 32'h7);
        do_update(8'hFF, 1'b0, 1'b1);
        lookup_valid = 0;
        #1 chk("recover_ghr_cat", 32'(gs0), 0);
        chk("recover_ghr_xor", 32'(gs1), 0);
        chk("recover_cnt_cat", 32'(cnt0), 1);
        chk("recover_cnt_xor", 32'(cnt1), 1);

        // read-before-write on the same index
        pc = 8'h20;
        update_valid = 1; update_index = 8'h20; update_outcome = 1;
        #1 chk("rbw_old_value", 32'(pred1), 0);
        cyc();
        clear_inputs();
        #1 chk("rbw_new_value", 32'(pred1), 1);

        // shape ghr_arch to 0110 and recover into ghr_spec
        do_update(8'hFF, 1'b1, 1'b0);
        do_update(8'hFF, 1'b0, 1'b1);
        pc = 8'hA5;
        #1 chk("ghr_spec_0110", 32'(gs0), 32'h6);
        chk("hash_xor_a5", 32'(idx1), 32'hA3);
        chk("hash_cat_a5", 32'(idx0), 32'h56);

        do_update(8'hFF, 1'b0, 1'b1);
        #1 chk("cnt2_reaches_max", 32'(cnt1), 3);
        do_update(8'hFF, 1'b0, 1'b1);
        do_update(8'hFF, 1'b0, 1'b1);
        #1 chk("cnt2_saturated", 32'(cnt1), 3);
        chk("cnt16_five", 32'(cnt0), 5);

        // reset, activity during the sweep, then reset again at ptr 100
        rst = 1;
        cyc();
        rst = 0;
        lookup_valid = 1; update_valid = 1; update_index = 8'h35;
        update_outcome = 1; update_mispredict = 1;
        for (int i = 0; i < 100; i++) cyc();
        rst = 1;
        cyc();
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            #1 chk("resweep_not_ready", 32'(rdy0), 0);
            cyc();
        end
        clear_inputs();
        #1 chk("resweep_ready", 32'(rdy0), 1);
        chk("init_updates_no_count", 32'(cnt0), 0);
        chk("init_lookups_no_ghr", 32'(gs0), 0);
        pc = 8'h20;
        #1 chk("resweep_cleared_20", 32'(pred1), 0);
        pc = 8'h13;
        #1 chk("resweep_cleared_13", 32'(pred1), 0);
        do_update(8'h00, 1'b1, 1'b1);
        #1 chk("arch_untouched_in_init", 32'(gs0), 1);

        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
